// File: rtl/seg7_pkg.sv
// Shared types and cathode patterns for the seven-segment scan controller.
// Cathode patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment cathode decode.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner stepped by rising edges of led_clk,
// with an all-dark gap at each digit change and per-frame latching of display data.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        led_clk,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int              CNT_W    = 18;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    logic              r_sync_p0;
    logic              r_sync_p1;
    logic              r_prev;
    logic [2:0]        r_arm;
    logic              w_tick;

    scan_state_t       r_state;
    scan_state_t       w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [2:0]        w_idx_step;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_load;
    logic              r_load_p;

    logic [31:0]       r_sh_data;
    logic [7:0]        r_sh_dp;
    logic [7:0]        r_sh_blank;

    logic [3:0]        w_nibble;
    logic [6:0]        w_seg_dec;
    logic              w_show;

    logic [7:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp_n;
    logic              r_frame_start;

    // Edge detection; r_arm holds off ticks until the synchroniser and prev flop
    // carry real samples, so a led_clk already high at release is not an edge.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_prev    <= 1'b0;
            r_arm     <= 3'b000;
        end else begin
            r_sync_p0 <= led_clk;
            r_sync_p1 <= r_sync_p0;
            r_prev    <= r_sync_p1;
            r_arm     <= {r_arm[1:0], 1'b1};
        end
    end

    assign w_tick     = r_sync_p1 & ~r_prev & r_arm[2];
    assign w_idx_step = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_idx_nxt   = 3'd0;
                    w_load      = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SHOW;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_SHOW: begin
                if (w_tick) begin
                    w_idx_nxt   = w_idx_step;
                    w_load      = (w_idx_step == 3'd0);
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_BLANK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_load_p   <= 1'b0;
            r_sh_data  <= 32'h0;
            r_sh_dp    <= 8'h0;
            r_sh_blank <= 8'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_load_p <= w_load;
            if (w_load) begin
                r_sh_data  <= data;
                r_sh_dp    <= dp;
                r_sh_blank <= blank;
            end
        end
    end

    assign w_nibble = r_sh_data[{r_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Blanked digits go fully dark, cathodes included.
    assign w_show = (r_state == ST_SHOW) && !r_sh_blank[r_idx];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_an          <= 8'hFF;
            r_seg         <= SEG_OFF;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_show ? ~(8'h01 << r_idx) : 8'hFF;
            r_seg         <= w_show ? w_seg_dec : SEG_OFF;
            r_dp_n        <= w_show ? ~r_sh_dp[r_idx] : 1'b1;
            r_frame_start <= r_load_p;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: vector table of per-digit expectations plus
// hand-written reset, idle and async-reset sequences.
module tb_seg7_scan_ctrl;

    localparam int NUM_DIGITS   = 8;
    localparam int BLANK_CYCLES = 10;
    localparam int HALF_PERIOD  = 1000;
    localparam int NVEC         = 21;

    logic        clk;
    logic        rst_n;
    logic        led_clk;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_start;

    int n_tests;
    int n_fail;
    int onehot_viol;
    int fs_cycles;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dp_n;
        logic        fs;
    } vec_t;

    vec_t vecs [NVEC];

    seg7_scan_ctrl #(
        .NUM_DIGITS   (NUM_DIGITS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk_in      (clk),
        .reset       (rst_n),
        .led_clk     (led_clk),
        .data        (data),
        .dp          (dp),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        onehot_viol = 0;
        fs_cycles   = 0;
    end

    always @(negedge clk) begin
        if ($countones(~an) > 1) onehot_viol++;
        if (frame_start === 1'b1) fs_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_dark();
        return (an === 8'hFF) && (seg === 7'h7F) && (dp_n === 1'b1);
    endfunction

    task automatic chk_dark(input string name);
        chk({name, "_an"}, 32'(an), 32'hFF);
        chk({name, "_seg"}, 32'(seg), 32'h7F);
        chk({name, "_dpn"}, 32'(dp_n), 32'h1);
    endtask

    // One full led_clk period starting with a rising edge; called at a negedge with led_clk low.
    task automatic run_vec(input int i);
        vec_t v;
        int   used;
        int   gap;
        v       = vecs[i];
        data    = v.data;
        dp      = v.dp;
        blank   = v.blank;
        led_clk = 1'b1;
        used    = 0;
        repeat (3) begin
            @(negedge clk);
            used++;
        end
        chk($sformatf("v%0d_fs_early", i), 32'(frame_start), 32'h0);
        @(negedge clk);
        used++;
        chk($sformatf("v%0d_fs", i), 32'(frame_start), 32'(v.fs));
        gap = 0;
        while (is_dark() && gap < BLANK_CYCLES + 20) begin
            gap++;
            if (gap == 2) chk($sformatf("v%0d_fs_width", i), 32'(frame_start), 32'h0);
            @(negedge clk);
            used++;
        end
        if (v.an != 8'hFF) begin
            chk($sformatf("v%0d_gap", i), 32'(gap), 32'(BLANK_CYCLES));
            chk($sformatf("v%0d_an", i), 32'(an), 32'(v.an));
            chk($sformatf("v%0d_seg", i), 32'(seg), 32'(v.seg));
            chk($sformatf("v%0d_dpn", i), 32'(dp_n), 32'(v.dp_n));
        end else begin
            chk($sformatf("v%0d_blanked_an", i), 32'(an), 32'hFF);
        end
        repeat (HALF_PERIOD - used) @(negedge clk);
        chk($sformatf("v%0d_an_hold", i), 32'(an), 32'(v.an));
        led_clk = 1'b0;
        repeat (HALF_PERIOD) @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // inputs {data, dp, blank}, expected {an, seg, dp_n, frame_start}
        vecs[0]  = '{32'h89AB_CDEF, 8'h01, 8'h00, 8'hFE, 7'b0001110, 1'b0, 1'b1};
        vecs[1]  = '{32'h89AB_CDEF, 8'h01, 8'h00, 8'hFD, 7'b0000110, 1'b1, 1'b0};
        vecs[2]  = '{32'h89AB_CDEF, 8'h01, 8'h00, 8'hFB, 7'b0100001, 1'b1, 1'b0};
        vecs[3]  = '{32'h89AB_CDEF, 8'h01, 8'h00, 8'hF7, 7'b1000110, 1'b1, 1'b0};
        vecs[4]  = '{32'h0000_0000, 8'h01, 8'h00, 8'hEF, 7'b0000011, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 8'h01, 8'h00, 8'hDF, 7'b0001000, 1'b1, 1'b0};
        vecs[6]  = '{32'h0000_0000, 8'h01, 8'h00, 8'hBF, 7'b0010000, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_0000, 8'h01, 8'h00, 8'h7F, 7'b0000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFE, 7'b1000000, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFF, 7'h7F,      1'b1, 1'b0};
        vecs[10] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFB, 7'b1000000, 1'b1, 1'b0};
        vecs[11] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFF, 7'h7F,      1'b1, 1'b0};
        vecs[12] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hEF, 7'b1000000, 1'b1, 1'b0};
        vecs[13] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFF, 7'h7F,      1'b1, 1'b0};
        vecs[14] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hBF, 7'b1000000, 1'b1, 1'b0};
        vecs[15] = '{32'h0000_0000, 8'h01, 8'hAA, 8'hFF, 7'h7F,      1'b1, 1'b0};
        vecs[16] = '{32'h89AB_CDEF, 8'h08, 8'h00, 8'hFE, 7'b0001110, 1'b1, 1'b1};
        vecs[17] = '{32'h89AB_CDEF, 8'h08, 8'h00, 8'hFD, 7'b0000110, 1'b1, 1'b0};
        vecs[18] = '{32'h89AB_CDEF, 8'h08, 8'h00, 8'hFB, 7'b0100001, 1'b1, 1'b0};
        vecs[19] = '{32'h89AB_CDEF, 8'h08, 8'h00, 8'hF7, 7'b1000110, 1'b0, 1'b0};
        vecs[20] = '{32'h89AB_CDEF, 8'h08, 8'h00, 8'hFE, 7'b0001110, 1'b1, 1'b1};

        rst_n   = 1'b0;
        led_clk = 1'b0;
        data    = 32'h89AB_CDEF;
        dp      = 8'h01;
        blank   = 8'h00;

        // Reset held with led_clk toggling; ends with led_clk high.
        for (int k = 0; k < 11; k++) begin
            repeat (3) @(negedge clk);
            led_clk = ~led_clk;
            chk_dark($sformatf("rst%0d", k));
            chk($sformatf("rst%0d_fs", k), 32'(frame_start), 32'h0);
        end

        // Release with led_clk already high: no tick may result.
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk_dark("idle_hi");
        chk("idle_hi_fs_count", 32'(fs_cycles), 32'h0);
        led_clk = 1'b0;
        repeat (20) @(negedge clk);
        chk_dark("idle_lo");

        for (int i = 0; i < 20; i++) run_vec(i);

        // Asynchronous reset while digit 3 is lit, away from any clock edge.
        chk("pre_rst_an", 32'(an), 32'hF7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dark("async_rst");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_dark("post_rst_idle");
        run_vec(20);

        chk("onehot_anodes", 32'(onehot_viol), 32'h0);
        chk("frame_start_cycles", 32'(fs_cycles), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
